// File: rtl/play_scheduler.sv
// play_scheduler: song step sequencer and note arbiter for the music player.
// Drives the song ROM address, gates playback with play/pause/stop and a
// tempo select, and picks the note for the tone generator. A live keypad
// note always overrides the song note. The song keeps advancing underneath.
//
// Handshake: there is no valid/ready pair here. btn_play and btn_stop are
// single-cycle pulses, and each one is acted on at the clk edge that samples
// it. song_index is combinational from song_step and is taken in the same
// cycle. All outputs are registered, or decoded straight from the state
// register.
module play_scheduler #(
    parameter int TICK_DIV = 3125000,
    parameter int SONG_LEN = 192,
    parameter int STEP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_play,
    input  logic              btn_stop,
    input  logic              loop_en,
    input  logic [1:0]        tempo_sel,
    input  logic [4:0]        key_index,
    input  logic [4:0]        song_index,
    output logic [STEP_W-1:0] song_step,
    output logic [4:0]        note_index,
    output logic              playing,
    output logic              paused,
    output logic              beat_tick,
    output logic              song_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // The counter is wide enough for the slowest tempo (2*TICK_DIV).
    localparam int CNT_W = $clog2(2 * TICK_DIV);
    localparam logic [CNT_W-1:0]  TERM_NORM = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  TERM_FAST = CNT_W'(TICK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  TERM_SLOW = CNT_W'(2 * TICK_DIV - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SONG_LEN - 1);

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] term;
    logic             tick;
    logic             at_last;

    // Terminal count for the current tempo. The >= compare means a tempo
    // change that leaves the count past the new terminal ticks at once.
    always_comb begin
        term = TERM_NORM;
        case (tempo_sel)
            2'd1:    term = TERM_FAST;
            2'd2:    term = TERM_SLOW;
            default: term = TERM_NORM;
        endcase
        tick    = (state == PLAY) && (tick_cnt >= term);
        at_last = (song_step >= LAST_STEP);
    end

    // Status flags are decoded straight from the state register.
    assign playing = (state == PLAY);
    assign paused  = (state == PAUSE);

    // Main sequencer: state, step counter, tick counter, note arbitration and pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            song_step  <= '0;
            note_index <= '0;
            beat_tick  <= 1'b0;
            song_done  <= 1'b0;
        end else begin
            beat_tick  <= 1'b0;
            song_done  <= 1'b0;
            note_index <= (state == PLAY && key_index == 5'd0) ? song_index : key_index;
            if (btn_stop) begin
                state     <= IDLE;
                song_step <= '0;
                tick_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (btn_play) begin
                            state     <= PLAY;
                            song_step <= '0;
                            tick_cnt  <= '0;
                        end
                    end
                    PLAY: begin
                        if (tick) begin
                            tick_cnt <= '0;
                            if (!at_last) begin
                                song_step <= song_step + 1'b1;
                                beat_tick <= 1'b1;
                                if (btn_play) state <= PAUSE;
                            end else if (loop_en) begin
                                song_step <= '0;
                                beat_tick <= 1'b1;
                                if (btn_play) state <= PAUSE;
                            end else begin
                                // The song has ended. This takes priority over a pause request.
                                state     <= IDLE;
                                song_step <= '0;
                                song_done <= 1'b1;
                            end
                        end else begin
                            // The count still advances on the edge that takes a pause.
                            tick_cnt <= tick_cnt + 1'b1;
                            if (btn_play) state <= PAUSE;
                        end
                    end
                    PAUSE: begin
                        if (btn_play) state <= PLAY;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_play_scheduler.sv
// Testbench for play_scheduler with TICK_DIV=4, SONG_LEN=8, STEP_W=3.
// A table of single-cycle vectors covers start, arbitration, pause/resume and stop.
// Hand-written sequences cover full songs, looping, long pause, keypad hold,
// async reset and tempo switching.
module tb_play_scheduler;

    logic       clk;
    logic       reset;
    logic       btn_play;
    logic       btn_stop;
    logic       loop_en;
    logic [1:0] tempo_sel;
    logic [4:0] key_index;
    logic [4:0] song_index;
    logic [2:0] song_step;
    logic [4:0] note_index;
    logic       playing;
    logic       paused;
    logic       beat_tick;
    logic       song_done;

    int checks = 0;
    int errors = 0;

    play_scheduler #(
        .TICK_DIV(4),
        .SONG_LEN(8),
        .STEP_W  (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_play  (btn_play),
        .btn_stop  (btn_stop),
        .loop_en   (loop_en),
        .tempo_sel (tempo_sel),
        .key_index (key_index),
        .song_index(song_index),
        .song_step (song_step),
        .note_index(note_index),
        .playing   (playing),
        .paused    (paused),
        .beat_tick (beat_tick),
        .song_done (song_done)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       bp;
        logic       bs;
        logic [4:0] key;
        logic [4:0] song;
        logic [2:0] e_step;
        logic [4:0] e_note;
        logic       e_play;
        logic       e_pause;
        logic       e_beat;
        logic       e_done;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] e_step, input logic [4:0] e_note,
                             input logic e_play, input logic e_pause, input logic e_beat,
                             input logic e_done);
        check({tag, " step"},  32'(song_step),  32'(e_step));
        check({tag, " note"},  32'(note_index), 32'(e_note));
        check({tag, " play"},  32'(playing),    32'(e_play));
        check({tag, " pause"}, 32'(paused),     32'(e_pause));
        check({tag, " beat"},  32'(beat_tick),  32'(e_beat));
        check({tag, " done"},  32'(song_done),  32'(e_done));
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn_play   = 1'b0;
        btn_stop   = 1'b0;
        key_index  = 5'd0;
        reset      = 1'b0;
        #1;
        check_out("reset", 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step_clk();
        reset = 1'b1;
    endtask

    task automatic press_play();
        btn_play = 1'b1;
        step_clk();
        btn_play = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        btn_play   = 1'b0;
        btn_stop   = 1'b0;
        loop_en    = 1'b0;
        tempo_sel  = 2'd0;
        key_index  = 5'd0;
        song_index = 5'd0;
        #2;

        // vector table: bp, bs, key, song, step, note, play, pause, beat, done
        vecs[0]  = '{1'b1, 1'b0, 5'd0,  5'd7,  3'd0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0,  5'd29, 3'd0, 5'd29, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 5'd25, 5'd29, 3'd0, 5'd25, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 5'd25, 5'd29, 3'd0, 5'd25, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 5'd25, 5'd29, 3'd1, 5'd25, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  5'd3,  3'd1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 5'd0,  5'd4,  3'd1, 5'd4,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 5'd2,  5'd9,  3'd1, 5'd2,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 5'd0,  5'd9,  3'd1, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 5'd0,  5'd9,  3'd1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 5'd0,  5'd6,  3'd1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  5'd6,  3'd2, 5'd6,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 5'd0,  5'd6,  3'd0, 5'd6,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 5'd0,  5'd6,  3'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};

        // table-driven vectors
        do_reset();
        for (int i = 0; i < 14; i++) begin
            btn_play   = vecs[i].bp;
            btn_stop   = vecs[i].bs;
            key_index  = vecs[i].key;
            song_index = vecs[i].song;
            step_clk();
            check_out($sformatf("vec%0d", i), vecs[i].e_step, vecs[i].e_note, vecs[i].e_play,
                      vecs[i].e_pause, vecs[i].e_beat, vecs[i].e_done);
        end
        btn_play = 1'b0;
        btn_stop = 1'b0;

        // basic play, no loop: 8 steps then song_done
        do_reset();
        loop_en    = 1'b0;
        song_index = 5'd3;
        press_play();
        check("s1 start play", 32'(playing), 32'd1);
        for (int k = 1; k <= 33; k++) begin
            step_clk();
            check($sformatf("s1 k%0d step", k), 32'(song_step), (k < 32) ? 32'(k / 4) : 32'd0);
            check($sformatf("s1 k%0d beat", k), 32'(beat_tick), (k % 4 == 0 && k < 32) ? 32'd1 : 32'd0);
            check($sformatf("s1 k%0d play", k), 32'(playing), (k < 32) ? 32'd1 : 32'd0);
            check($sformatf("s1 k%0d done", k), 32'(song_done), (k == 32) ? 32'd1 : 32'd0);
        end

        // looping: 10 periods, wrap 7 -> 0 with beat_tick
        do_reset();
        loop_en = 1'b1;
        press_play();
        for (int k = 1; k <= 40; k++) begin
            step_clk();
            check($sformatf("s2 k%0d step", k), 32'(song_step), 32'((k / 4) % 8));
            check($sformatf("s2 k%0d beat", k), 32'(beat_tick), (k % 4 == 0) ? 32'd1 : 32'd0);
            check($sformatf("s2 k%0d play", k), 32'(playing), 32'd1);
            check($sformatf("s2 k%0d done", k), 32'(song_done), 32'd0);
        end

        // pause one cycle after the tick into step 3, hold, resume
        do_reset();
        loop_en = 1'b0;
        press_play();
        for (int k = 1; k <= 12; k++) step_clk();
        check("s3 tick into 3 beat", 32'(beat_tick), 32'd1);
        check("s3 tick into 3 step", 32'(song_step), 32'd3);
        press_play();
        check("s3 paused", 32'(paused), 32'd1);
        check("s3 not playing", 32'(playing), 32'd0);
        for (int k = 0; k < 20; k++) begin
            step_clk();
            check($sformatf("s3 hold%0d step", k), 32'(song_step), 32'd3);
            check($sformatf("s3 hold%0d beat", k), 32'(beat_tick), 32'd0);
            check($sformatf("s3 hold%0d pause", k), 32'(paused), 32'd1);
        end
        press_play();
        check("s3 resume play", 32'(playing), 32'd1);
        check("s3 resume beat", 32'(beat_tick), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step_clk();
            check($sformatf("s3 r%0d beat", k), 32'(beat_tick), (k == 3) ? 32'd1 : 32'd0);
            check($sformatf("s3 r%0d step", k), 32'(song_step), (k == 3) ? 32'd4 : 32'd3);
        end

        // keypad override held for 6 cycles while the song advances
        do_reset();
        loop_en    = 1'b1;
        song_index = 5'd29;
        press_play();
        step_clk();
        check("s4 song note", 32'(note_index), 32'd29);
        key_index = 5'd25;
        for (int k = 2; k <= 7; k++) begin
            step_clk();
            check($sformatf("s4 k%0d note", k), 32'(note_index), 32'd25);
            check($sformatf("s4 k%0d step", k), 32'(song_step), 32'(k / 4));
        end
        key_index = 5'd0;
        step_clk();
        check("s4 release note", 32'(note_index), 32'd29);
        check("s4 release step", 32'(song_step), 32'd2);
        check("s4 release beat", 32'(beat_tick), 32'd1);

        // async reset mid-period
        #3;
        reset = 1'b0;
        #1;
        check_out("s5 async", 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step_clk();
        reset = 1'b1;
        step_clk();
        check_out("s5 after", 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // tempo select: fast, slow, then slow -> fast at count 5
        do_reset();
        loop_en   = 1'b1;
        tempo_sel = 2'd1;
        press_play();
        for (int k = 1; k <= 8; k++) begin
            step_clk();
            check($sformatf("s6 fast k%0d beat", k), 32'(beat_tick), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        tempo_sel = 2'd2;
        for (int k = 9; k <= 21; k++) begin
            step_clk();
            check($sformatf("s6 slow k%0d beat", k), 32'(beat_tick), (k == 16) ? 32'd1 : 32'd0);
        end
        tempo_sel = 2'd1;
        step_clk();
        check("s6 switch beat", 32'(beat_tick), 32'd1);
        step_clk();
        check("s6 after switch beat", 32'(beat_tick), 32'd0);
        step_clk();
        check("s6 fast again beat", 32'(beat_tick), 32'd1);
        check("s6 final step", 32'(song_step), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
